// File: rtl/philv_trace_buffer.sv
// Philosophy-V on-chip trace buffer: circular pre-trigger capture,
// programmable post-trigger window, oldest-first valid/ready drain.
module philv_trace_buffer #(
  parameter int N        = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int POST     = 8,
  parameter int TS_W     = 16
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            arm,
  input  logic                            sample_valid,
  input  logic                            trig_in,
  input  logic [CHANNELS*N-1:0]           ch_data,
  input  logic                            rd_ready,
  output logic                            rd_valid,
  output logic [TS_W+CHANNELS*N-1:0]      rd_data,
  output logic                            rd_last,
  output logic [1:0]                      state,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + CHANNELS*N;
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);
  localparam logic [AW-1:0] POST_L = AW'(POST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_READ  = 2'd3
  } st_t;

  st_t             r_state;
  logic [TS_W-1:0] r_ts;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_post_left;
  logic [AW:0]     r_count;
  logic [EW-1:0]   r_mem [DEPTH];

  logic            w_wr;
  logic [AW-1:0]   w_wr_nxt;
  logic [AW:0]     w_cnt_inc;
  logic [AW-1:0]   w_rd_start;

  assign w_wr = sample_valid &
                ((r_state == S_ARMED) | (r_state == S_POST));
  assign w_wr_nxt  = r_wr_ptr + ONE_P;
  assign w_cnt_inc = (r_count == FULL) ? r_count : r_count + ONE_C;
  // Oldest entry as seen after the final write lands.
  assign w_rd_start = w_wr_nxt - w_cnt_inc[AW-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_ts        <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_left <= '0;
      r_count     <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state  <= S_ARMED;
            r_wr_ptr <= '0;
            r_count  <= '0;
          end
        end
        S_ARMED: begin
          if (w_wr) begin
            r_wr_ptr <= w_wr_nxt;
            r_count  <= w_cnt_inc;
            if (trig_in) begin
              if (POST == 0) begin
                r_state  <= S_READ;
                r_rd_ptr <= w_rd_start;
              end else begin
                r_post_left <= POST_L;
                r_state     <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (w_wr) begin
            r_wr_ptr    <= w_wr_nxt;
            r_count     <= w_cnt_inc;
            r_post_left <= r_post_left - ONE_P;
            if (r_post_left == ONE_P) begin
              r_state  <= S_READ;
              r_rd_ptr <= w_rd_start;
            end
          end
        end
        S_READ: begin
          if (rd_ready) begin
            r_rd_ptr <= r_rd_ptr + ONE_P;
            r_count  <= r_count - ONE_C;
            if (r_count == ONE_C) begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Storage is never reset; stale contents are unreachable.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {r_ts, ch_data};
    end
  end

  assign rd_valid = (r_state == S_READ);
  assign rd_last  = rd_valid & (r_count == ONE_C);
  assign rd_data  = r_mem[r_rd_ptr];
  assign state    = r_state;
  assign count    = r_count;

endmodule

// File: tb/tb_philv_trace_buffer.sv
// Bench for philv_trace_buffer: table of capture scenarios over two
// instances (POST=8/TS_W=16 and POST=0/TS_W=4) against a queue model.
module tb_philv_trace_buffer;

  localparam int N     = 16;
  localparam int CH    = 2;
  localparam int DEPTH = 16;
  localparam int TSA   = 16;
  localparam int TSB   = 4;
  localparam int DW    = CH*N;
  localparam int EWA   = TSA + DW;
  localparam int EWB   = TSB + DW;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          arm_a = 1'b0;
  logic          arm_b = 1'b0;
  logic          sample_valid = 1'b0;
  logic          trig_in = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] ch_data = '0;

  logic           a_valid, a_last, b_valid, b_last;
  logic [EWA-1:0] a_data;
  logic [EWB-1:0] b_data;
  logic [1:0]     a_state, b_state;
  logic [4:0]     a_count, b_count;

  always #5 clk = ~clk;

  philv_trace_buffer #(
    .N(N), .CHANNELS(CH), .DEPTH(DEPTH), .POST(8), .TS_W(TSA)
  ) u_a (
    .clk(clk), .rstb(rstb), .arm(arm_a),
    .sample_valid(sample_valid), .trig_in(trig_in),
    .ch_data(ch_data), .rd_ready(rd_ready),
    .rd_valid(a_valid), .rd_data(a_data), .rd_last(a_last),
    .state(a_state), .count(a_count)
  );

  philv_trace_buffer #(
    .N(N), .CHANNELS(CH), .DEPTH(DEPTH), .POST(0), .TS_W(TSB)
  ) u_b (
    .clk(clk), .rstb(rstb), .arm(arm_b),
    .sample_valid(sample_valid), .trig_in(trig_in),
    .ch_data(ch_data), .rd_ready(rd_ready),
    .rd_valid(b_valid), .rd_data(b_data), .rd_last(b_last),
    .state(b_state), .count(b_count)
  );

  bit            sel = 1'b0;
  logic          m_valid, m_last;
  logic [15:0]   m_ts;
  logic [DW-1:0] m_data;
  logic [1:0]    m_state;
  logic [4:0]    m_count;

  assign m_valid = sel ? b_valid : a_valid;
  assign m_last  = sel ? b_last  : a_last;
  assign m_ts    = sel ? {12'b0, b_data[EWB-1 -: TSB]}
                       : a_data[EWA-1 -: TSA];
  assign m_data  = sel ? b_data[DW-1:0] : a_data[DW-1:0];
  assign m_state = sel ? b_state : a_state;
  assign m_count = sel ? b_count : a_count;

  int cyc;
  always @(posedge clk or negedge rstb) begin
    if (!rstb) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0]   ts;
    logic [DW-1:0] d;
  } ent_t;

  ent_t hist[$];
  ent_t win[$];

  task automatic put(input logic [DW-1:0] d);
    logic [15:0] t;
    t = sel ? 16'(cyc & 15) : 16'(cyc & 16'hFFFF);
    sample_valid = 1'b1;
    ch_data = d;
    hist.push_back('{ts: t, d: d});
  endtask

  typedef struct {
    bit s;
    int npre;
    bit gap;
    int rmode;
    bit rnd;
    int base;
    int exp_n;
    int exp_first;
    int exp_last;
    int abort;
  } vec_t;

  function automatic logic [DW-1:0] nextv(input vec_t v, input int k);
    return v.rnd ? DW'($urandom) : DW'(v.base + k);
  endfunction

  task automatic run(input vec_t v);
    int postv, n, k, wn, idx, budget;
    bit stalled;
    logic [15:0] hts;
    logic [DW-1:0] hd, firstd, lastd;
    postv = v.s ? 0 : 8;
    hist.delete();
    win.delete();
    sel = v.s;
    k = 0;
    if (v.s) arm_b = 1'b1;
    else     arm_a = 1'b1;
    step();
    arm_a = 1'b0;
    arm_b = 1'b0;
    chk("armed", 64'(m_state), 64'd1);
    n = 0;
    while (n < v.npre) begin
      if (v.gap && $urandom_range(0, 2) == 0) begin
        sample_valid = 1'b0;
        trig_in = 1'($urandom_range(0, 1));
        step();
        chk("trig_no_sv", 64'(m_state), 64'd1);
      end else begin
        put(nextv(v, k));
        k++;
        trig_in = 1'b0;
        n++;
        step();
      end
    end
    put(nextv(v, k));
    k++;
    trig_in = 1'b1;
    step();
    trig_in = 1'b0;
    sample_valid = 1'b0;
    if (postv == 0) begin
      chk("post0_valid", 64'(m_valid), 64'd1);
      chk("post0_state", 64'(m_state), 64'd3);
    end else begin
      chk("post_trig_state", 64'(m_state), 64'd2);
    end
    n = 0;
    while (n < postv) begin
      trig_in = 1'($urandom_range(0, 1));
      if (v.gap && $urandom_range(0, 2) == 0) begin
        sample_valid = 1'b0;
      end else begin
        put(nextv(v, k));
        k++;
        n++;
      end
      step();
      if (n < postv) chk("post_hold", 64'(m_state), 64'd2);
    end
    sample_valid = 1'b0;
    trig_in = 1'b0;
    chk("readout_state", 64'(m_state), 64'd3);
    chk("readout_valid", 64'(m_valid), 64'd1);
    wn = hist.size() < DEPTH ? hist.size() : DEPTH;
    for (int i = hist.size() - wn; i < hist.size(); i++)
      win.push_back(hist[i]);
    chk("count_window", 64'(m_count), 64'(wn));
    if (v.exp_n >= 0) chk("count_table", 64'(m_count), 64'(v.exp_n));
    idx = 0;
    budget = 0;
    stalled = 1'b0;
    firstd = '0;
    lastd = '0;
    while (idx < wn && budget < 200) begin
      case (v.rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (budget % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      sample_valid = 1'($urandom_range(0, 1));
      trig_in = 1'($urandom_range(0, 1));
      ch_data = DW'($urandom);
      if (budget == 0) begin
        if (v.s) arm_b = 1'b1;
        else     arm_a = 1'b1;
      end
      chk("rd_valid_hold", 64'(m_valid), 64'd1);
      if (stalled) chk("stall_stable", {m_ts, m_data}, {hts, hd});
      if (rd_ready) begin
        chk("rd_data", 64'(m_data), 64'(win[idx].d));
        chk("rd_ts", 64'(m_ts), 64'(win[idx].ts));
        chk("rd_last", 64'(m_last), 64'(idx == wn - 1));
        if (idx == 0) firstd = m_data;
        lastd = m_data;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hts = m_ts;
        hd = m_data;
      end
      step();
      arm_a = 1'b0;
      arm_b = 1'b0;
      if (budget == 0 && idx < wn) chk("arm_in_readout", 64'(m_state), 64'd3);
      budget++;
      if (v.abort >= 0 && idx == v.abort) begin
        rd_ready = 1'b0;
        sample_valid = 1'b0;
        trig_in = 1'b0;
        #2 rstb = 1'b0;
        #1;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_state", 64'(m_state), 64'd0);
        chk("rst_count", 64'(m_count), 64'd0);
        #3 rstb = 1'b1;
        step();
        return;
      end
    end
    chk("readout_done", 64'(idx), 64'(wn));
    rd_ready = 1'b0;
    sample_valid = 1'b0;
    trig_in = 1'b0;
    chk("end_state", 64'(m_state), 64'd0);
    chk("end_count", 64'(m_count), 64'd0);
    chk("end_valid", 64'(m_valid), 64'd0);
    if (v.exp_n >= 0 && v.abort < 0) begin
      chk("first_entry", 64'(firstd), 64'(v.exp_first));
      chk("last_entry", 64'(lastd), 64'(v.exp_last));
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, 3, 0, 0, 0, 1, 12, 1, 12, -1});
    vecs.push_back('{0, 40, 0, 0, 0, 0, 16, 33, 48, -1});
    vecs.push_back('{1, 4, 0, 0, 0, 1, 5, 1, 5, -1});
    vecs.push_back('{0, 3, 0, 0, 0, 1, 12, 1, 12, 3});
    vecs.push_back('{0, 3, 0, 0, 0, 1, 12, 1, 12, -1});
    vecs.push_back('{0, 0, 0, 1, 0, 100, 9, 100, 108, -1});
    vecs.push_back('{1, 30, 0, 1, 0, 0, 16, 15, 30, -1});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{bit'(i % 2), int'($urandom_range(0, 25)),
                       1, 2, 1, 0, -1, 0, 0, -1});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_state", 64'(a_state), 64'd0);
    chk("reset_a_valid", 64'(a_valid), 64'd0);
    chk("reset_a_last", 64'(a_last), 64'd0);
    chk("reset_a_count", 64'(a_count), 64'd0);
    chk("reset_b_state", 64'(b_state), 64'd0);
    chk("reset_b_valid", 64'(b_valid), 64'd0);
    rstb = 1'b1;
    step();

    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      trig_in = 1'b1;
      ch_data = DW'($urandom);
      step();
    end
    sample_valid = 1'b0;
    trig_in = 1'b0;
    chk("idle_sv_count_a", 64'(a_count), 64'd0);
    chk("idle_sv_count_b", 64'(b_count), 64'd0);
    chk("idle_sv_state_a", 64'(a_state), 64'd0);

    foreach (vecs[i]) run(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1);
  end

endmodule
